id_hazard_ctrl: RTL

Pipeline hazard and redirect controller for the decode stage. It keeps a shadow record of in-flight register writes in EX, MEM and WB, and uses it to stall decode on load-use and jump-register (JALR) dependencies. It also sequences PC redirects and fetch/decode flushes for jumps resolved in ID and branches resolved in EX, freezes everything on a memory stall, and counts lost cycles. It sits beside the ID stage and drives the PC mux and the IF/ID and ID/EX pipeline-register controls.

---
 rtl/id_hazard_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard/redirect controller: tracks in-flight register writes in EX/MEM/WB,
// stalls on load-use and JALR dependencies, sequences jump/branch redirects and counts stalls.
module id_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_wr_rd,
  input  logic             id_is_load,
  input  logic             id_jmp,
  input  logic [1:0]       id_jb_sel,
  input  logic             ex_br_taken,
  input  logic             mem_stall,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             pc_sel_jmp,
  output logic             pc_sel_br,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             ex_v_q, ex_v_d, ex_ld_q, ex_ld_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             mem_v_q, mem_v_d;
  logic [4:0]       mem_rd_q, mem_rd_d;
  logic             wb_v_q, wb_v_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic rs1_ex, rs2_ex, rs1_mem, rs1_wb;
  logic load_use, jalr_dep, hazard;
  logic br_redirect, jmp_redirect, hz_stall;

  always_comb begin
    rs1_ex  = ex_v_q  && id_use_rs1 && (id_rs1 != 5'd0) && (id_rs1 == ex_rd_q);
    rs2_ex  = ex_v_q  && id_use_rs2 && (id_rs2 != 5'd0) && (id_rs2 == ex_rd_q);
    rs1_mem = mem_v_q && id_use_rs1 && (id_rs1 != 5'd0) && (id_rs1 == mem_rd_q);
    rs1_wb  = wb_v_q  && id_use_rs1 && (id_rs1 != 5'd0) && (id_rs1 == wb_rd_q);

    load_use = id_valid && ex_ld_q && (rs1_ex || rs2_ex);
    // WB must also match: the regfile write lands too late for a same-cycle read.
    jalr_dep = id_valid && id_jmp && (id_jb_sel == 2'b10) && (rs1_ex || rs1_mem || rs1_wb);
    hazard   = load_use || jalr_dep;

    br_redirect  = !rst && ex_br_taken && !mem_stall;
    hz_stall     = !rst && hazard && !br_redirect && !mem_stall;
    jmp_redirect = !rst && id_valid && id_jmp && !hazard && !br_redirect && !mem_stall;

    freeze       = !rst && mem_stall;
    pc_sel_br    = br_redirect;
    flush_id_ex  = br_redirect;
    stall_if_id  = hz_stall;
    bubble_id_ex = hz_stall;
    pc_sel_jmp   = jmp_redirect;
    flush_if_id  = br_redirect || jmp_redirect;
    stall_cnt    = cnt_q;
  end

  always_comb begin
    ex_v_d   = ex_v_q;
    ex_rd_d  = ex_rd_q;
    ex_ld_d  = ex_ld_q;
    mem_v_d  = mem_v_q;
    mem_rd_d = mem_rd_q;
    wb_v_d   = wb_v_q;
    wb_rd_d  = wb_rd_q;
    cnt_d    = cnt_q;
    if (!freeze) begin
      wb_v_d   = mem_v_q;
      wb_rd_d  = mem_rd_q;
      mem_v_d  = ex_v_q;
      mem_rd_d = ex_rd_q;
      ex_v_d   = id_valid && id_wr_rd && (id_rd != 5'd0) && !bubble_id_ex && !flush_id_ex;
      ex_rd_d  = id_rd;
      ex_ld_d  = id_is_load;
    end
    if ((stall_if_id || freeze) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_q   <= 1'b0;
      ex_rd_q  <= 5'd0;
      ex_ld_q  <= 1'b0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= 5'd0;
      wb_v_q   <= 1'b0;
      wb_rd_q  <= 5'd0;
      cnt_q    <= '0;
    end else begin
      ex_v_q   <= ex_v_d;
      ex_rd_q  <= ex_rd_d;
      ex_ld_q  <= ex_ld_d;
      mem_v_q  <= mem_v_d;
      mem_rd_q <= mem_rd_d;
      wb_v_q   <= wb_v_d;
      wb_rd_q  <= wb_rd_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
